// File: rtl/byte_line_packer.sv
// Packs a byte-serial Avalon-ST packet stream into big-endian W-bit line words
// carrying sop/eop/empty, sustaining one byte per cycle with a single output register.
module byte_line_packer #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [B-1:0]                 in_data,
  input  logic                         in_sop,
  input  logic                         in_eop,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [W-1:0]                 out_data,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [$clog2(W/B)-1:0]       out_empty,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned BpW  = W / B;
  localparam int unsigned IdxW = $clog2(BpW);

  typedef enum logic {StIdle, StPack} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              first_word_q, first_word_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic [IdxW-1:0]   out_empty_q, out_empty_d;
  logic              out_valid_q, out_valid_d;

  logic              byte_acc;
  logic              active;
  logic [W-1:0]      base_acc;
  logic [IdxW-1:0]   base_idx;
  logic              base_first;
  logic [W-1:0]      merged;

  assign in_ready  = !reset && (!out_valid_q || out_ready);
  assign byte_acc  = in_valid && in_ready;

  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_empty = out_empty_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    first_word_d = first_word_q;
    out_data_d   = out_data_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_empty_d  = out_empty_q;
    out_valid_d  = out_valid_q && !out_ready;

    // A sop byte always restarts from slot 0, dropping any partial word in flight.
    base_acc   = acc_q;
    base_idx   = idx_q;
    base_first = first_word_q;
    active     = (state_q == StPack);
    if (in_sop) begin
      base_acc   = '0;
      base_idx   = '0;
      base_first = 1'b1;
      active     = 1'b1;
    end

    merged = base_acc;
    for (int unsigned k = 0; k < BpW; k++) begin
      if (base_idx == IdxW'(k)) begin
        merged[W-1-B*k -: B] = in_data;
      end
    end

    if (byte_acc && active) begin
      if (base_idx == IdxW'(BpW - 1) || in_eop) begin
        out_data_d   = merged;
        out_sop_d    = base_first;
        out_eop_d    = in_eop;
        out_empty_d  = in_eop ? (IdxW'(BpW - 1) - base_idx) : '0;
        out_valid_d  = 1'b1;
        acc_d        = '0;
        idx_d        = '0;
        first_word_d = 1'b0;
        state_d      = in_eop ? StIdle : StPack;
      end else begin
        acc_d        = merged;
        idx_d        = base_idx + 1'b1;
        first_word_d = base_first;
        state_d      = StPack;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      idx_q        <= '0;
      first_word_q <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      first_word_q <= first_word_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: doc/byte_line_packer.md
# byte_line_packer

Packs a byte-wide Avalon-ST packet stream into `Line`-format words (`W`-bit data, `sop`, `eop`, `empty`) for the `avln_st` datapath. It sits directly upstream of any `avln_st` consumer and converts a byte-serial source (UART/parser side) into full-width beats. Symbol order is big-endian: the first byte of a word occupies the most significant bits. Sustained throughput is one input byte per cycle.

## Interface
- `B`, default `8` (from `global_types`): symbol width in bits.
- `W`, default `32` (from `global_types`): output word width in bits; `BpW = W/B` is derived, never overridden.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  B  input byte.
- `in_sop`  in  1  first byte of packet.
- `in_eop`  in  1  last byte of packet.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  block can accept a byte this cycle.
- `out_data`  out  W  packed word; byte k at bits `[W-1-B*k -: B]`.
- `out_sop`  out  1  first word of packet.
- `out_eop`  out  1  last word of packet.
- `out_empty`  out  $clog2(BpW)  count of unused low-order bytes; meaningful only with `out_eop`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts word.

## Operation
- Byte accepted when `in_valid && in_ready`. Word accepted when `out_valid && out_ready`.
- `in_ready = !reset && (!out_valid || out_ready)`; combinational, no other dependency.
- State: accumulator `acc[W-1:0]`, index `idx` (0..BpW-1), flag `in_pkt`, flag `first_word`.
- States: IDLE (`in_pkt=0`), PACK (`in_pkt=1`).
- IDLE: byte without `in_sop` is accepted and discarded. Byte with `in_sop` enters PACK; it is written to slot 0, `first_word=1`.
- PACK: each accepted byte writes slot `idx`. Bytes in slots above the last written one are zero.
- Word completion on the accepted byte when `idx==BpW-1` or `in_eop`:
  - Output register loads `acc` with the new byte merged. `out_sop=first_word`, `out_eop=in_eop`, `out_empty = in_eop ? BpW-1-idx : 0`. `out_valid=1`.
  - `acc` is cleared, `idx=0`, `first_word=0`.
  - If `in_eop`, return to IDLE.
- If not completing, `idx` increments.
- Byte with `in_sop && in_eop` forms a 1-byte packet: `out_sop=out_eop=1`, `out_empty=BpW-1`.
- `in_sop` while in PACK:
  - The current partial word (`idx>0`) is discarded and is never emitted.
  - Words of the aborted packet already emitted stay as sent; no eop is generated for them.
  - The new byte starts a fresh packet in slot 0 with `first_word=1`.
- `in_eop` while in IDLE without `in_sop`: discarded, as any byte outside a packet.
- Output register holds all `out_*` stable while `out_valid && !out_ready`.
- `out_valid` clears on acceptance unless a new word loads the same cycle.
- Reset (any cycle, including mid-packet):
  - `out_valid=0`, `out_data=0`, `out_sop=0`, `out_eop=0`, `out_empty=0`.
  - `acc=0`, `idx=0`, `in_pkt=0`, `first_word=0`.
  - Any partial or pending word is dropped.

## Timing
- Latency: a word appears (`out_valid=1`) the cycle after the byte that completes it is accepted.
- With `out_ready` held high: one byte per cycle in. A full word leaves every BpW cycles with no bubble.
- Backpressure: `in_ready` falls in the same cycle as `out_valid && !out_ready`. No byte is lost or duplicated.
- Accept and load in the same cycle: when `out_ready=1` and a word completes, the old word leaves and the new word loads.
- Zero-bubble guarantee: `in_ready` stays high across back-to-back word completions.
- Reset takes effect at the first rising edge where it is sampled high. The first legal `in_valid` is the cycle after reset deasserts.

## Test plan
- Aligned packet: bytes 11,22,33,44 (sop on 11, eop on 44), `out_ready=1` -> one word `0x11223344`, sop=1, eop=1, empty=0, valid one cycle after byte 44.
- Unaligned packet: bytes 01..06 -> `0x01020304` sop=1 eop=0 empty=0, then `0x05060000` sop=0 eop=1 empty=2.
- Single-byte packet: `0xAA` with sop=eop=1 -> `0xAA000000`, sop=1, eop=1, empty=3.
- Backpressure: 8-byte packet, `out_ready=0` for 5 cycles after first word -> `in_ready=0` throughout, `out_*` stable, both words delivered intact after release, no byte loss.
- Sop mid-packet and stray bytes: bytes 0x77 (no sop), then sop 0xA1, 0xA2, then sop 0xB1..0xB4 eop -> only `0xB1B2B3B4` (sop=1, eop=1, empty=0) emitted.
- Reset mid-packet: sop 0xC1, 0xC2, assert reset 1 cycle, then packet 0xD1..0xD4 -> all outputs 0 during reset; only `0xD1D2D3D4` emitted afterwards.
